regfile_rd: RTL and testbench

Register file with one write port and two registered, handshaked read ports (A and B), for the decode stage of the pipelined core.
- Storage is an array of write-enabled flops; register 0 is hardwired to zero.
- The read side captures addresses on an accepted request and presents data one cycle later.
- Read data holds stable under downstream stall, so decode can stall without re-reading.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_rd_port.sv | 63 ++++++
 rtl/regfile_rd.sv | 99 +++++++++
 tb/tb_regfile_rd.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the decode-stage register file.
//   DATA_W_DEFAULT / ADDR_W_DEFAULT : default data and index widths
//   NREGS                           : register count at the default index width
//   ZERO_REG                        : index of the hardwired-zero register
//   reg_addr_t / reg_data_t         : index and data types at the default widths
package regfile_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT = 5;
  localparam int unsigned NREGS          = 2 ** ADDR_W_DEFAULT;
  localparam int unsigned ZERO_REG       = 0;

  typedef logic [ADDR_W_DEFAULT-1:0] reg_addr_t;
  typedef logic [DATA_W_DEFAULT-1:0] reg_data_t;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port of the register file.
// Selects a register by index, forces index 0 to zero, and captures the result
// into the output register only when a request is accepted, so the data holds
// for as long as the port is not re-accepted (downstream stall).
// Build option: REGFILE_RD_BYPASS_EN forwards a same-cycle write to the read.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   accept_i      : request accepted this cycle, capture new data
//   rd_addr_i     : register index to read
//   regs_i        : current storage contents
//   wr_en_i, wr_addr_i, wr_data_i : write port, used for the bypass
//   rd_data_o     : registered read data
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              accept_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  always_comb begin
    sel_data = regs_i[rd_addr_i];
    if (rd_addr_i == ADDR_W'(ZERO_REG)) begin
      sel_data = '0;
`ifdef REGFILE_RD_BYPASS_EN
    end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      // Write-before-read: the value being written this edge wins.
      sel_data = wr_data_i;
`endif
    end
  end

`ifndef REGFILE_RD_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

  // Only an accept loads; otherwise the snapshot is held.
  assign rd_data_d = accept_i ? sel_data : rd_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/regfile_rd.sv
// regfile_rd: register file with one write port and two registered, handshaked
// read ports (A, B) for the decode stage. Register 0 reads as zero.
// Build option: REGFILE_RD_BYPASS_EN makes a same-cycle write visible to an
// accepted read of the same index.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   wr_en, wr_addr, wr_data     : write port
//   rd_req, rd_ready            : read request / read side can accept
//   rd_addr_a, rd_addr_b        : read indices
//   rd_stall                    : downstream cannot consume this cycle
//   rd_valid, rd_data_a/b       : registered read result
module regfile_rd
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              rd_stall,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic              rd_valid_d, rd_valid_q;
  logic              accept;

  // Entry 0 is kept at zero; the ports also force index 0 to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wr_en && (wr_addr != ADDR_W'(ZERO_REG))) begin
        regs_q[wr_addr] <= wr_data;
      end
      regs_q[0] <= '0;
    end
  end

  assign rd_ready = !(rd_valid_q && rd_stall);
  assign accept   = rd_req && rd_ready;

  // Stays full on accept or while stalled; empties on consume without accept.
  assign rd_valid_d = accept || (rd_valid_q && rd_stall);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid = rd_valid_q;

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_a (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .accept_i  (accept),
    .rd_addr_i (rd_addr_a),
    .regs_i    (regs_q),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_data_o (rd_data_a)
  );

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port_b (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .accept_i  (accept),
    .rd_addr_i (rd_addr_b),
    .regs_i    (regs_q),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_data_o (rd_data_b)
  );

endmodule

// File: tb/tb_regfile_rd.sv
// tb_regfile_rd: scoreboard bench for regfile_rd. The driver keeps a plain
// array model of the register file, pushes the expected pair for every
// accepted read; the monitor compares whenever rd_valid is presented and pops
// when the result is consumed.
module tb_regfile_rd;
  import regfile_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic          rd_stall = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;

  int total = 0;
  int bad = 0;

  exp_t          sb_q[$];
  logic [DW-1:0] mem [2**AW];
  logic          m_valid = 1'b0;

  regfile_rd #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_ready  (rd_ready),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_stall  (rd_stall),
    .rd_valid  (rd_valid),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Value an accepted read of addr should return, given this cycle's write.
  function automatic logic [DW-1:0] model_val(input logic [AW-1:0] addr, input logic we,
                                              input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (addr == 0) return '0;
`ifdef REGFILE_RD_BYPASS_EN
    if (we && wa == addr) return wd;
`endif
    return mem[addr];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rd_req = 1'b1;
    rd_stall = 1'b0;
    wr_en = 1'b1;
    wr_addr = 5'd5;
    wr_data = $urandom;
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd5;
    sb_q.delete();
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    m_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_valid", 32'(rd_valid), 32'd0);
    chk("reset_data_a", rd_data_a, '0);
    chk("reset_data_b", rd_data_b, '0);
  endtask

  task automatic cycle(input logic req, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic stall, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
    logic exp_ready;
    logic acc;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    rd_req = req;
    rd_addr_a = a;
    rd_addr_b = b;
    rd_stall = stall;
    wr_en = we;
    wr_addr = wa;
    wr_data = wd;
    #1;
    exp_ready = !(m_valid && stall);
    chk("rd_ready", 32'(rd_ready), 32'(exp_ready));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    acc = req && exp_ready;
    if (acc) begin
      e.a = model_val(a, we, wa, wd);
      e.b = model_val(b, we, wa, wd);
      sb_q.push_back(e);
    end
    if (we && wa != 0) mem[wa] = wd;
    m_valid = acc || (m_valid && stall);
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, wa, wd);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    cycle(1'b1, a, b, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: compare every presented result; pop when it is consumed.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got rd_valid=1 expected no result at %0t", $time);
      end else begin
        chk("rd_data_a", rd_data_a, sb_q[0].a);
        chk("rd_data_b", rd_data_b, sb_q[0].b);
        if (rd_stall !== 1'b1) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    do_reset();
    rd(5'd9, 5'd31);
    // Basic read
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd0);
    idle();
    // Zero register write is ignored
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    idle();
    // Stall hold with snapshot semantics
    wr(5'd3, 32'h11);
    rd(5'd3, 5'd3);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 32'h22);
    idle();
    idle();
    // Same-cycle write/read, then re-read
    wr(5'd7, 32'h1);
    cycle(1'b1, 5'd7, 5'd7, 1'b0, 1'b1, 5'd7, 32'h2);
    rd(5'd7, 5'd0);
    idle();
    // Back-to-back
    wr(5'd1, 32'hA);
    wr(5'd2, 32'hB);
    wr(5'd3, 32'hC);
    rd(5'd1, 5'd1);
    rd(5'd2, 5'd2);
    rd(5'd3, 5'd3);
    idle();
    idle();
    // Randomized traffic with a mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
            $urandom);
    end
    for (int i = 0; i < 3; i++) idle();
    @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
